// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory access scheduler.
package mem_sched_pkg;

  // Scheduler sequence: pick requester(s), load MAR(s), access memory.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_MAR = 2'd1,
    ACCESS   = 2'd2
  } state_e;

  // Requester ids: R0 is the CPU path, R1 the loader/debug path.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // One-hot port-select masks for the captured transaction.
  localparam logic [1:0] PORT_A = 2'b01;
  localparam logic [1:0] PORT_B = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with an optional dual grant for read pairs.
module rr_arbiter2
  import mem_sched_pkg::*;
#(
  parameter bit DUAL_ISSUE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       both_read_i,
  output logic [1:0] grant_o
);

  logic rr_last_q, rr_last_d;

  // Grant selection; rr_last only moves when a real conflict was resolved.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_o   = 2'b00;
    rr_last_d = rr_last_q;
    unique case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        if (DUAL_ISSUE && both_read_i) begin
          grant_o = 2'b11;
        end else if (rr_last_q == REQ_CPU) begin
          grant_o   = 2'b10;
          rr_last_d = REQ_LDR;
        end else begin
          grant_o   = 2'b01;
          rr_last_d = REQ_CPU;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

  // Round-robin pointer; resets to the loader so the CPU wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) rr_last_q <= REQ_LDR;
    else      rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/mem_access_sched.sv
// Schedules R0/R1 accesses onto the MAR pair and the dual-port memory:
// grant in IDLE, load MAR(s), access memory, then pulse the response.
module mem_access_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter bit DUAL_ISSUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata0,
  output logic [DATA_WIDTH-1:0] rsp_rdata1,
  output logic                  mar_a_load,
  output logic [ADDR_WIDTH-1:0] mar_a_addr,
  output logic                  mar_b_load,
  output logic [ADDR_WIDTH-1:0] mar_b_addr,
  output logic                  mem_load_a,
  output logic                  mem_oe_a,
  output logic [DATA_WIDTH-1:0] mem_wdata_a,
  output logic                  mem_oe_b,
  input  logic [DATA_WIDTH-1:0] mem_dout_a,
  input  logic [DATA_WIDTH-1:0] mem_dout_b,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [1:0]            grant, hs;
  logic                  a_id_q, a_we_q;
  logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q;
  logic [DATA_WIDTH-1:0] a_wdata_q;
  logic [1:0]            port_sel_q;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata0_q, rsp_rdata0_d, rsp_rdata1_q, rsp_rdata1_d;
  logic                  in_load, in_access;

  // Arbiter only sees requests while idle, so grants depend on registered state.
  rr_arbiter2 #(.DUAL_ISSUE(DUAL_ISSUE)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       ((state_q == IDLE) ? req_valid : 2'b00),
    .both_read_i (~req_we[0] & ~req_we[1]),
    .grant_o     (grant)
  );

  assign req_ready = grant;
  assign hs        = req_valid & grant;
  assign busy      = (state_q != IDLE);
  assign in_load   = (state_q == LOAD_MAR);
  assign in_access = (state_q == ACCESS);

  // Fixed three-step sequence; leaves IDLE only on a handshake.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:     state_d = (|hs) ? LOAD_MAR : IDLE;
      LOAD_MAR: state_d = ACCESS;
      ACCESS:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Memory-side strobes; buses are zero outside the cycle that uses them.
  always_comb begin
    mar_a_load  = in_load & |(port_sel_q & PORT_A);
    mar_a_addr  = mar_a_load ? a_addr_q : '0;
    mar_b_load  = in_load & |(port_sel_q & PORT_B);
    mar_b_addr  = mar_b_load ? b_addr_q : '0;
    mem_load_a  = in_access & a_we_q;
    mem_wdata_a = mem_load_a ? a_wdata_q : '0;
    mem_oe_a    = in_access & ~a_we_q;
    mem_oe_b    = in_access & |(port_sel_q & PORT_B);
  end

  // Response capture at the ACCESS edge; read data holds until the next response.
  always_comb begin
    rsp_valid_d  = 2'b00;
    rsp_rdata0_d = rsp_rdata0_q;
    rsp_rdata1_d = rsp_rdata1_q;
    if (in_access) begin
      rsp_valid_d[a_id_q] = 1'b1;
      if (a_id_q == REQ_CPU) rsp_rdata0_d = a_we_q ? '0 : mem_dout_a;
      else                   rsp_rdata1_d = a_we_q ? '0 : mem_dout_a;
      if (|(port_sel_q & PORT_B)) begin
        rsp_valid_d[REQ_LDR] = 1'b1;
        rsp_rdata1_d         = mem_dout_b;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata0 = rsp_rdata0_q;
  assign rsp_rdata1 = rsp_rdata1_q;

  // State, captured request and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      a_id_q       <= REQ_CPU;
      a_we_q       <= 1'b0;
      a_addr_q     <= '0;
      a_wdata_q    <= '0;
      b_addr_q     <= '0;
      port_sel_q   <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata0_q <= '0;
      rsp_rdata1_q <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata0_q <= rsp_rdata0_d;
      rsp_rdata1_q <= rsp_rdata1_d;
      if (hs == 2'b11) begin
        // Read pair: R0 on port A, R1 on port B.
        a_id_q     <= REQ_CPU;
        a_we_q     <= 1'b0;
        a_addr_q   <= req_addr0;
        a_wdata_q  <= '0;
        b_addr_q   <= req_addr1;
        port_sel_q <= PORT_A | PORT_B;
      end else if (|hs) begin
        a_id_q     <= hs[1];
        a_we_q     <= hs[1] ? req_we[1] : req_we[0];
        a_addr_q   <= hs[1] ? req_addr1 : req_addr0;
        a_wdata_q  <= hs[1] ? req_wdata1 : req_wdata0;
        b_addr_q   <= '0;
        port_sel_q <= PORT_A;
      end
    end
  end

endmodule
